phy_rx_framer: RTL and testbench



---
 rtl/phy_rx_pkg.sv | 29 ++
 rtl/phy_rx_fifo.sv | 54 +++++
 rtl/phy_rx_framer.sv | 217 +++++++++++++++++++++
 tb/tb_phy_rx_framer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/phy_rx_pkg.sv
// Shared types and constants for the MII-family receive framer.
package phy_rx_pkg;

    localparam logic [7:0] SFD = 8'hD5;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        DROP,
        FLUSH
    } state_t;

    typedef struct packed {
        logic       err;
        logic       last;
        logic [7:0] data;
    } fifo_entry_t;

    // Preamble symbol as seen on a PHY_W-bit bus (0x55 split into symbols).
    function automatic logic [7:0] pre_sym(input int phy_w);
        case (phy_w)
            2:       return 8'h01;
            8:       return 8'h55;
            default: return 8'h05;
        endcase
    endfunction

endpackage

// File: rtl/phy_rx_fifo.sv
// First-word-fall-through FIFO; output reads as zero while empty.
module phy_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [W-1:0]           wr_data,
    input  logic                   rd_en,
    output logic [W-1:0]           rd_data,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_wr;
    logic          do_rd;

    assign do_rd = rd_en && (cnt != '0);
    // A write into a full FIFO is fine when the same cycle frees an entry.
    assign do_wr = wr_en && ((cnt != CW'(DEPTH)) || do_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    assign valid   = (cnt != '0);
    assign rd_data = valid ? mem[rd_ptr] : '0;
    assign level   = cnt;

endmodule

// File: rtl/phy_rx_framer.sv
// Receive front end: strips preamble/SFD, packs PHY symbols into bytes, buffers them.
//   state | meaning
//   IDLE  | waiting for dv
//   PRE   | counting preamble symbols, looking for SFD
//   DATA  | packing bytes, one byte held back to tag the last
//   DROP  | ignoring the rest of a bad or over-long frame
//   FLUSH | final entry waiting for FIFO space; new frames are discarded
module phy_rx_framer
    import phy_rx_pkg::*;
#(
    parameter int PHY_W      = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_LEN    = 1518,
    parameter int PRE_MIN    = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          phy_rx_dv,
    input  logic [PHY_W-1:0]              phy_rxd,
    output logic [7:0]                    m_data,
    output logic                          m_last,
    output logic                          m_err,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              frame_cnt,
    output logic [CNT_W-1:0]              err_cnt
);

    localparam int               BEATS     = 8 / PHY_W;
    localparam logic [2:0]       LAST_BEAT = 3'(BEATS - 1);
    localparam int               LW        = $clog2(FIFO_DEPTH) + 1;
    localparam int               BCW       = $clog2(MAX_LEN + 1) + 1;
    localparam int               PCW       = $clog2(PRE_MIN + 1) + 1;
    localparam int               CW1       = CNT_W + 1;
    localparam logic [7:0]       PRE_PAT   = pre_sym(PHY_W);
    localparam logic [PHY_W-1:0] PRE_SYM   = PRE_PAT[PHY_W-1:0];

    state_t           state, state_d;
    logic [7:0]       sr, sr_d, sr_shift;
    logic [7:0]       hold, hold_d;
    logic             hvld, hvld_d;
    logic             sticky, sticky_d;
    logic             dv_q;
    logic [2:0]       bc, bc_d;
    logic [BCW-1:0]   bcnt, bcnt_d;
    logic [PCW-1:0]   pcnt, pcnt_d;
    fifo_entry_t      pend, pend_d, push_ent, out_ent;
    logic             push_req, wr_en, drop_evt, space, pop;
    logic             inc_frame;
    logic [1:0]       err_inc;
    logic [CNT_W:0]   err_sum;

    // New symbols enter at the MSB end so the first one lands in the low bits.
    if (PHY_W == 8) begin : g_sr8
        assign sr_shift = phy_rxd;
    end else begin : g_srn
        assign sr_shift = {phy_rxd, sr[7:PHY_W]};
    end

    assign pop   = m_valid && m_ready;
    assign space = (fifo_level != LW'(FIFO_DEPTH)) || pop;

    always_comb begin
        state_d  = state;
        sr_d     = sr;
        pcnt_d   = pcnt;
        bc_d     = bc;
        bcnt_d   = bcnt;
        hold_d   = hold;
        hvld_d   = hvld;
        sticky_d = sticky;
        pend_d   = pend;
        push_req = 1'b0;
        push_ent = '0;
        drop_evt = 1'b0;
        wr_en    = 1'b0;

        case (state)
            IDLE: begin
                if (phy_rx_dv) begin
                    sr_d    = sr_shift;
                    pcnt_d  = PCW'(1);
                    state_d = PRE;
                end
            end
            PRE: begin
                if (!phy_rx_dv) begin
                    state_d = IDLE;
                end else begin
                    sr_d = sr_shift;
                    if (sr_shift == SFD && pcnt >= PCW'(PRE_MIN)) begin
                        state_d  = DATA;
                        bc_d     = '0;
                        bcnt_d   = '0;
                        hvld_d   = 1'b0;
                        sticky_d = 1'b0;
                    end else if (phy_rxd != PRE_SYM) begin
                        state_d  = DROP;
                        drop_evt = 1'b1;
                    end else if (pcnt < PCW'(PRE_MIN)) begin
                        pcnt_d = pcnt + PCW'(1);
                    end
                end
            end
            DATA: begin
                if (phy_rx_dv) begin
                    sr_d = sr_shift;
                    if (bc == LAST_BEAT) begin
                        bc_d = '0;
                        if (bcnt == BCW'(MAX_LEN)) begin
                            push_req = 1'b1;
                            push_ent = '{err: 1'b1, last: 1'b1, data: hold};
                            state_d  = DROP;
                        end else begin
                            bcnt_d = bcnt + BCW'(1);
                            hold_d = sr_shift;
                            hvld_d = 1'b1;
                            if (hvld) begin
                                push_req = 1'b1;
                                push_ent = '{err: 1'b0, last: 1'b0, data: hold};
                            end
                        end
                    end else begin
                        bc_d = bc + 3'd1;
                    end
                end else begin
                    state_d = IDLE;
                    if (hvld) begin
                        push_req = 1'b1;
                        push_ent = '{err: sticky || (bc != 3'd0), last: 1'b1, data: hold};
                    end else begin
                        drop_evt = 1'b1;
                    end
                end
            end
            DROP: begin
                if (!phy_rx_dv) state_d = IDLE;
            end
            FLUSH: begin
                push_req = 1'b1;
                push_ent = pend;
                drop_evt = phy_rx_dv && !dv_q;
                // Any frame that began here is discarded to its end.
                if (space) state_d = phy_rx_dv ? DROP : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (push_req) begin
            if (space) begin
                wr_en = 1'b1;
            end else if (!push_ent.last) begin
                sticky_d = 1'b1;
            end else begin
                pend_d  = push_ent;
                state_d = FLUSH;
            end
        end

        if (state_d == IDLE) sr_d = '0;
    end

    assign inc_frame = wr_en && push_ent.last && !push_ent.err;
    assign err_inc   = 2'(wr_en && push_ent.last && push_ent.err) + 2'(drop_evt);
    assign err_sum   = {1'b0, err_cnt} + CW1'(err_inc);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            pcnt      <= '0;
            bc        <= '0;
            bcnt      <= '0;
            hold      <= '0;
            hvld      <= 1'b0;
            sticky    <= 1'b0;
            pend      <= '0;
            dv_q      <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            state  <= state_d;
            sr     <= sr_d;
            pcnt   <= pcnt_d;
            bc     <= bc_d;
            bcnt   <= bcnt_d;
            hold   <= hold_d;
            hvld   <= hvld_d;
            sticky <= sticky_d;
            pend   <= pend_d;
            dv_q   <= phy_rx_dv;
            if (inc_frame && frame_cnt != '1) frame_cnt <= frame_cnt + CNT_W'(1);
            err_cnt <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
        end
    end

    phy_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(fifo_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (push_ent),
        .rd_en   (m_ready),
        .rd_data (out_ent),
        .valid   (m_valid),
        .level   (fifo_level)
    );

    assign m_data = out_ent.data;
    assign m_last = out_ent.last;
    assign m_err  = out_ent.err;

endmodule

// File: tb/tb_phy_rx_framer.sv
// Directed bench for phy_rx_framer: MII defaults, a short MAX_LEN MII variant and an RMII variant.
module tb_phy_rx_framer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // MII, default parameters
    logic       dv4 = 1'b0, rdy4 = 1'b0;
    logic [3:0] rxd4 = '0;
    logic [7:0] data4;
    logic       last4, err4, val4;
    logic [4:0] lvl4;
    logic [15:0] fcnt4, ecnt4;

    // MII, MAX_LEN = 4
    logic       dvl = 1'b0, rdyl = 1'b0;
    logic [3:0] rxdl = '0;
    logic [7:0] datal;
    logic       lastl, errl, vall;
    logic [4:0] lvll;
    logic [15:0] fcntl, ecntl;

    // RMII
    logic       dv2 = 1'b0, rdy2 = 1'b0;
    logic [1:0] rxd2 = '0;
    logic [7:0] data2;
    logic       last2, err2, val2;
    logic [4:0] lvl2;
    logic [15:0] fcnt2, ecnt2;

    phy_rx_framer #(.PHY_W(4)) u_d4 (
        .clk(clk), .rst(rst), .phy_rx_dv(dv4), .phy_rxd(rxd4),
        .m_data(data4), .m_last(last4), .m_err(err4), .m_valid(val4), .m_ready(rdy4),
        .fifo_level(lvl4), .frame_cnt(fcnt4), .err_cnt(ecnt4)
    );

    phy_rx_framer #(.PHY_W(4), .MAX_LEN(4)) u_dl (
        .clk(clk), .rst(rst), .phy_rx_dv(dvl), .phy_rxd(rxdl),
        .m_data(datal), .m_last(lastl), .m_err(errl), .m_valid(vall), .m_ready(rdyl),
        .fifo_level(lvll), .frame_cnt(fcntl), .err_cnt(ecntl)
    );

    phy_rx_framer #(.PHY_W(2)) u_d2 (
        .clk(clk), .rst(rst), .phy_rx_dv(dv2), .phy_rxd(rxd2),
        .m_data(data2), .m_last(last2), .m_err(err2), .m_valid(val2), .m_ready(rdy2),
        .fifo_level(lvl2), .frame_cnt(fcnt2), .err_cnt(ecnt2)
    );

    // Popped entries {err,last,data}, sampled mid-cycle when inputs and outputs are stable.
    logic [9:0] q4[$];
    logic [9:0] ql[$];
    logic [9:0] q2[$];

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (val4 && rdy4) q4.push_back({err4, last4, data4});
            if (vall && rdyl) ql.push_back({errl, lastl, datal});
            if (val2 && rdy2) q2.push_back({err2, last2, data2});
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qat(input int sel, input int i);
        case (sel)
            0:       return (i < q4.size()) ? 32'(q4[i]) : 32'hBAD;
            1:       return (i < ql.size()) ? 32'(ql[i]) : 32'hBAD;
            default: return (i < q2.size()) ? 32'(q2[i]) : 32'hBAD;
        endcase
    endfunction

    task automatic send(input int sel, input logic [3:0] s);
        case (sel)
            0:       begin dv4 = 1'b1; rxd4 = s; end
            1:       begin dvl = 1'b1; rxdl = s; end
            default: begin dv2 = 1'b1; rxd2 = s[1:0]; end
        endcase
        @(negedge clk);
    endtask

    task automatic quiet(input int sel, input int n);
        case (sel)
            0:       begin dv4 = 1'b0; rxd4 = '0; end
            1:       begin dvl = 1'b0; rxdl = '0; end
            default: begin dv2 = 1'b0; rxd2 = '0; end
        endcase
        repeat (n) @(negedge clk);
    endtask

    task automatic preamble4(input int sel);
        repeat (15) send(sel, 4'h5);
        send(sel, 4'hD);
    endtask

    task automatic byte4(input int sel, input logic [7:0] b);
        send(sel, b[3:0]);
        send(sel, b[7:4]);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_valid",     32'(val4),  0);
        chk("rst_data",      32'(data4), 0);
        chk("rst_last",      32'(last4), 0);
        chk("rst_err",       32'(err4),  0);
        chk("rst_level",     32'(lvl4),  0);
        chk("rst_frame_cnt", 32'(fcnt4), 0);
        chk("rst_err_cnt",   32'(ecnt4), 0);
        rst = 1'b0; rdy4 = 1'b1; rdyl = 1'b1; rdy2 = 1'b1;
        @(negedge clk);

        // good MII frame
        q4.delete();
        preamble4(0);
        byte4(0, 8'h12);
        byte4(0, 8'h34);
        dv4 = 1'b0; rxd4 = '0;
        @(negedge clk);
        chk("good_last_out", 32'({val4, last4, err4, data4}), 32'({1'b1, 1'b1, 1'b0, 8'h34}));
        chk("good_fcnt_now", 32'(fcnt4), 1);
        quiet(0, 5);
        chk("good_n",     32'(q4.size()), 2);
        chk("good_e0",    qat(0, 0), 32'({2'b00, 8'h12}));
        chk("good_e1",    qat(0, 1), 32'({2'b01, 8'h34}));
        chk("good_fcnt",  32'(fcnt4), 1);
        chk("good_ecnt",  32'(ecnt4), 0);

        // odd nibble before dv fall
        q4.delete();
        preamble4(0);
        byte4(0, 8'h12);
        byte4(0, 8'h34);
        send(0, 4'h7);
        quiet(0, 6);
        chk("odd_n",    32'(q4.size()), 2);
        chk("odd_e0",   qat(0, 0), 32'({2'b00, 8'h12}));
        chk("odd_e1",   qat(0, 1), 32'({2'b11, 8'h34}));
        chk("odd_ecnt", 32'(ecnt4), 1);
        chk("odd_fcnt", 32'(fcnt4), 1);

        // SFD after too short a preamble
        q4.delete();
        send(0, 4'h5); send(0, 4'h5); send(0, 4'hD);
        send(0, 4'h2); send(0, 4'h1);
        quiet(0, 6);
        chk("short_n",     32'(q4.size()), 0);
        chk("short_ecnt",  32'(ecnt4), 2);
        chk("short_level", 32'(lvl4), 0);

        // back-pressure: 20 bytes into 16 entries, plus a frame arriving during FLUSH
        q4.delete();
        rdy4 = 1'b0;
        preamble4(0);
        for (int k = 1; k <= 20; k++) byte4(0, 8'(k));
        quiet(0, 3);
        chk("bp_level", 32'(lvl4), 16);
        chk("bp_head",  32'({val4, data4}), 32'({1'b1, 8'h01}));
        chk("bp_ecnt_pending", 32'(ecnt4), 2);
        preamble4(0);
        byte4(0, 8'h12);
        quiet(0, 3);
        chk("bp_flush_drop_ecnt", 32'(ecnt4), 3);
        chk("bp_flush_level",     32'(lvl4), 16);
        rdy4 = 1'b1;
        quiet(0, 30);
        chk("bp_n", 32'(q4.size()), 17);
        for (int i = 0; i < 16; i++)
            chk($sformatf("bp_e%0d", i), qat(0, i), 32'({2'b00, 8'(i + 1)}));
        chk("bp_e16",   qat(0, 16), 32'({2'b11, 8'h14}));
        chk("bp_ecnt",  32'(ecnt4), 4);
        chk("bp_fcnt",  32'(fcnt4), 1);
        chk("bp_level_end", 32'(lvl4), 0);

        // length limit, MAX_LEN = 4
        preamble4(1);
        for (int k = 0; k < 6; k++) byte4(1, 8'(8'hA1 + k));
        quiet(1, 6);
        chk("len_n",  32'(ql.size()), 4);
        chk("len_e0", qat(1, 0), 32'({2'b00, 8'hA1}));
        chk("len_e1", qat(1, 1), 32'({2'b00, 8'hA2}));
        chk("len_e2", qat(1, 2), 32'({2'b00, 8'hA3}));
        chk("len_e3", qat(1, 3), 32'({2'b11, 8'hA4}));
        chk("len_ecnt", 32'(ecntl), 1);
        chk("len_fcnt", 32'(fcntl), 0);

        // RMII frame
        repeat (7) send(2, 4'h1);
        send(2, 4'h3);
        send(2, 4'h2); send(2, 4'h0); send(2, 4'h1); send(2, 4'h0);
        quiet(2, 6);
        chk("rmii_n",    32'(q2.size()), 1);
        chk("rmii_e0",   qat(2, 0), 32'({2'b01, 8'h12}));
        chk("rmii_fcnt", 32'(fcnt2), 1);
        chk("rmii_ecnt", 32'(ecnt2), 0);

        // reset mid-frame, then data without a fresh preamble, then a clean frame
        q4.delete();
        preamble4(0);
        send(0, 4'h2); send(0, 4'h1); send(0, 4'h4);
        rst = 1'b1;
        send(0, 4'h3);
        chk("mrst_level", 32'(lvl4), 0);
        chk("mrst_valid", 32'(val4), 0);
        chk("mrst_fcnt",  32'(fcnt4), 0);
        chk("mrst_ecnt",  32'(ecnt4), 0);
        send(0, 4'h4);
        rst = 1'b0;
        send(0, 4'h3);
        send(0, 4'h4);
        quiet(0, 6);
        chk("mrst_tail_n",    32'(q4.size()), 0);
        chk("mrst_tail_ecnt", 32'(ecnt4), 1);
        chk("mrst_tail_fcnt", 32'(fcnt4), 0);
        preamble4(0);
        byte4(0, 8'h5A);
        quiet(0, 6);
        chk("mrst_next_n",    32'(q4.size()), 1);
        chk("mrst_next_e0",   qat(0, 0), 32'({2'b01, 8'h5A}));
        chk("mrst_next_fcnt", 32'(fcnt4), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
